// File: rtl/dds_wave_meter_if.sv
// Bundles the sample stream and the measurement result handshake of
// dds_wave_meter. The master side feeds samples and consumes results;
// the slave side is the meter itself.
interface dds_wave_meter_if #(
  parameter int m     = 12,
  parameter int CNT_W = 16
);
  logic             sample_en;
  logic [m-1:0]     sample;
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] period;
  logic [m-1:0]     peak_max;
  logic [m-1:0]     peak_min;
  logic             overflow;
  logic             overrun;

  modport master (
    output sample_en, sample, meas_ready,
    input  meas_valid, period, peak_max, peak_min, overflow, overrun
  );

  modport slave (
    input  sample_en, sample, meas_ready,
    output meas_valid, period, peak_max, peak_min, overflow, overrun
  );
endinterface

// File: rtl/dds_wave_meter.sv
// Waveform meter for the DDS sample stream: detects rising midscale
// crossings with hysteresis and reports period and peak values of each
// waveform cycle through a single-entry valid/ready result register.
module dds_wave_meter #(
  parameter int m     = 12,
  parameter int CNT_W = 16,
  parameter int HYST  = 64
) (
  input  logic             clk,
  input  logic             rst,
  dds_wave_meter_if.slave  bus
);

  localparam int HI_I = (1 << (m - 1)) + HYST;
  localparam int LO_I = (1 << (m - 1)) - HYST;
  localparam logic [m-1:0]     HI      = HI_I[m-1:0];
  localparam logic [m-1:0]     LO      = LO_I[m-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEEK, // waiting for the signal to go below LO
    ARM,  // below LO seen, waiting for the first rising edge
    HIGH, // inside a measured cycle, above LO
    LOW   // inside a measured cycle, below LO, next HI is an edge
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_hi;
  logic             w_lo;
  logic             w_start;
  logic             w_edge;
  logic             w_run;
  logic             w_hs;
  logic [CNT_W-1:0] w_period;
  logic             w_ovf;

  logic [CNT_W-1:0] r_cnt;
  logic [m-1:0]     r_pmax;
  logic [m-1:0]     r_pmin;

  logic             r_valid;
  logic [CNT_W-1:0] r_period;
  logic [m-1:0]     r_peak_max;
  logic [m-1:0]     r_peak_min;
  logic             r_overflow;
  logic             r_overrun;

  assign w_hi = (bus.sample >= HI);
  assign w_lo = (bus.sample <= LO);

  // Next-state and per-sample action decode; only accepted samples advance.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    w_next  = r_state;
    w_start = 1'b0;
    w_edge  = 1'b0;
    w_run   = 1'b0;
    if (bus.sample_en) begin
      unique case (r_state)
        SEEK: if (w_lo) w_next = ARM;
        ARM: begin
          if (w_hi) begin
            w_start = 1'b1;
            w_next  = HIGH;
          end
        end
        HIGH: begin
          w_run = 1'b1;
          if (w_lo) w_next = LOW;
        end
        LOW: begin
          if (w_hi) begin
            w_edge = 1'b1;
            w_next = HIGH;
          end else begin
            w_run = 1'b1;
          end
        end
        default: w_next = SEEK;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) r_state <= SEEK;
    else     r_state <= w_next;
  end

  // Period counter and running peaks of the current waveform cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pmax <= '0;
      r_pmin <= '0;
    end else if (w_start || w_edge) begin
      // The edge sample opens the next cycle.
      r_cnt  <= '0;
      r_pmax <= bus.sample;
      r_pmin <= bus.sample;
    end else if (w_run) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (bus.sample > r_pmax) r_pmax <= bus.sample;
      if (bus.sample < r_pmin) r_pmin <= bus.sample;
    end
  end

  // Once the counter sticks at its maximum the period is no longer exact.
  assign w_ovf    = (r_cnt == CNT_MAX);
  assign w_period = w_ovf ? CNT_MAX : r_cnt + 1'b1;
  assign w_hs     = r_valid & bus.meas_ready;

  // Single-entry result register; a result that finds it full is dropped.
  always_ff @(posedge clk) begin
    // NOTE: the result register is small and must read zero after reset,
    // so every field is reset, not just the valid flag.
    if (rst) begin
      r_valid    <= 1'b0;
      r_period   <= '0;
      r_peak_max <= '0;
      r_peak_min <= '0;
      r_overflow <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_edge) begin
      if (!r_valid || w_hs) begin
        r_valid    <= 1'b1;
        r_period   <= w_period;
        r_peak_max <= r_pmax;
        r_peak_min <= r_pmin;
        r_overflow <= w_ovf;
      end else begin
        r_overrun  <= 1'b1;
      end
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.meas_valid = r_valid;
  assign bus.period     = r_period;
  assign bus.peak_max   = r_peak_max;
  assign bus.peak_min   = r_peak_min;
  assign bus.overflow   = r_overflow;
  assign bus.overrun    = r_overrun;

endmodule
